// File: rtl/ext_pipe.sv
// ext_pipe: widens operands by zero/sign/ones-extension or left-alignment, buffered in a 2-entry FIFO.
module ext_pipe #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [15:0]      xfer_cnt
);
    logic [OUT_W-1:0] mem [2];
    logic [OUT_W-1:0] zx, ones, res;
    logic [1:0]       count;
    logic             head, tail, push, pop;
    // ones covers only the bits above the operand; it is empty when IN_W == OUT_W
    assign zx   = OUT_W'(in_data);
    assign ones = {OUT_W{1'b1}} << IN_W;
    always_comb begin
        res = in_mode == 2'd0 ? zx :
              in_mode == 2'd1 ? (in_data[IN_W-1] ? zx | ones : zx) :
              in_mode == 2'd2 ? zx | ones :
                                zx << (OUT_W - IN_W);
    end
    assign in_ready  = count < 2'd2;
    assign out_valid = count != 2'd0;
    assign out_data  = mem[head];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (push) tail <= ~tail;
            if (pop) begin
                head     <= ~head;
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= res;
    end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed checks of ext_pipe extension modes, flow control, reset and counter wrap.
module tb_ext_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [15:0] xfer_cnt;
    logic [7:0]  d8;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_data8;
    logic [15:0] xfer_cnt8;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    assign d8 = in_data[7:0];

    ext_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
    );

    ext_pipe #(.IN_W(8), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(d8), .in_mode(in_mode), .out_valid(out_valid8),
        .out_ready(out_ready), .out_data(out_data8), .xfer_cnt(xfer_cnt8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bitwise reference, built independently of the shift/mask formulation
    function automatic logic [15:0] ref_ext(input logic [9:0] d, input logic [1:0] m);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            if (m == 2'd3) r[i] = i >= 6 ? d[i-6] : 1'b0;
            else if (i < 10) r[i] = d[i];
            else r[i] = m == 2'd0 ? 1'b0 : m == 2'd1 ? d[9] : 1'b1;
        end
        return r;
    endfunction

    logic [9:0]  sw_d [5] = '{10'b1101100110, 10'b1000000000, 10'b0111111111, 10'b0011111111, 10'b1010101010};
    logic [1:0]  sw_m [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [15:0] sw_e [5] = '{16'h0366, 16'hFE00, 16'h01FF, 16'hFCFF, 16'hAA80};
    logic [7:0]  sw_e8 [5] = '{8'h66, 8'h00, 8'hFF, 8'hFF, 8'hAA};
    logic [15:0] exp_q [$];

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_xfer_cnt", xfer_cnt, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = sw_d[i]; in_mode = sw_m[i];
            @(negedge clk);
            in_valid = 1'b0;
            check("sweep_valid", out_valid, 1);
            check("sweep_data", out_data, sw_e[i]);
            check("sweep_ref", out_data, ref_ext(sw_d[i], sw_m[i]));
            check("equal_width_data", out_data8, sw_e8[i]);
            @(negedge clk);
        end
        check("sweep_xfer_cnt", xfer_cnt, 5);

        out_ready = 1'b0; in_mode = 2'd0;
        in_valid = 1'b1; in_data = 10'h001;
        @(negedge clk);
        check("bp_ready_1", in_ready, 1);
        in_data = 10'h002;
        @(negedge clk);
        check("bp_ready_full", in_ready, 0);
        in_data = 10'h003;
        @(negedge clk);
        check("bp_ready_held", in_ready, 0);
        check("bp_head_stable", out_data, 16'h0001);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_2", out_data, 16'h0002);
        check("bp_ready_again", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out_3", out_data, 16'h0003);
        check("bp_valid_3", out_valid, 1);
        @(negedge clk);
        check("bp_drained", out_valid, 0);
        check("bp_xfer_cnt", xfer_cnt, 8);

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 10'h200; in_mode = 2'd0;
        @(negedge clk);
        in_valid = 1'b0; in_mode = 2'd1;
        repeat (3) begin
            @(negedge clk);
            check("mode_change_data", out_data, 16'h0200);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("mode_change_drained", out_valid, 0);

        out_ready = 1'b0; in_mode = 2'd0;
        in_valid = 1'b1; in_data = 10'h005;
        @(negedge clk);
        in_data = 10'h006;
        @(negedge clk);
        check("midrst_full", in_ready, 0);
        in_data = 10'h007; out_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_xfer_cnt", xfer_cnt, 0);
        @(negedge clk);
        check("midrst_still_empty", out_valid, 0);
        check("midrst_no_count", xfer_cnt, 0);

        for (int i = 0; i <= 100; i++) begin
            if (i > 0) begin
                check("stream_valid", out_valid, 1);
                check("stream_data", out_data, exp_q.pop_front());
                check("stream_ready", in_ready, 1);
            end
            if (i < 100) begin
                in_valid = 1'b1;
                in_data = 10'($urandom_range(1023));
                in_mode = 2'($urandom_range(3));
                exp_q.push_back(ref_ext(in_data, in_mode));
            end else in_valid = 1'b0;
            @(negedge clk);
        end
        check("stream_xfer_cnt", xfer_cnt, 100);
        check("stream_empty", out_valid, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (65536) @(negedge clk);
        check("wrap_ffff", xfer_cnt, 16'hFFFF);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("wrap_cnt", xfer_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 10, meaning the input operand width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning the output width in bits; the legal range is IN_W <= OUT_W <= 64.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream operand is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand this cycle.
REQ-007 The block SHALL have port in_data, input, IN_W bits: the operand to extend.
REQ-008 The block SHALL have port in_mode, input, 2 bits, with these encodings:
- 00: zero-extend.
- 01: sign-extend.
- 10: ones-extend.
- 11: left-align.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port out_data, output, OUT_W bits: the extended result.
REQ-012 The block SHALL have port xfer_cnt, output, 16 bits: count of completed output transfers.

Function
REQ-013 The block SHALL treat an input transfer as in_valid && in_ready at a rising clk edge, and an output transfer as out_valid && out_ready at a rising clk edge.
REQ-014 The block SHALL compute the result at acceptance time from in_data and in_mode sampled at that edge; mode changes afterwards SHALL NOT affect a stored result.
REQ-015 The block SHALL apply these transforms:
- Zero-extend: upper OUT_W-IN_W bits are 0.
- Sign-extend: upper bits are copies of in_data[IN_W-1].
- Ones-extend: upper bits are 1.
- Left-align: out = in_data << (OUT_W-IN_W), with the low bits 0.
REQ-016 The block SHALL produce out_data == in_data in all modes when IN_W == OUT_W.
REQ-017 The block SHALL store results in a 2-entry FIFO with occupancy count in {0,1,2} and head/tail pointers that wrap modulo 2.
REQ-018 The block SHALL drive in_ready = (count < 2) from registered state only, with no combinational path from out_ready.
REQ-019 The block SHALL drive out_valid = (count > 0) and out_data = the head entry; out_data is don't-care when out_valid is 0.
REQ-020 The block SHALL have a latency of one cycle: an operand accepted at edge N into an empty FIFO is presented with out_valid=1 from edge N onward, i.e. visible in cycle N+1.
REQ-021 The block SHALL update occupancy on simultaneous input and output transfers as follows:
- count=1: count stays 1 and the new entry becomes head after the pop.
- count=2: no push is possible because in_ready=0, so a pop only gives count 1.
REQ-022 The block SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-023 The block SHALL sustain 1 transfer per cycle when out_ready is held high.
REQ-024 The block SHALL increment xfer_cnt by 1 on each output transfer, wrapping 0xFFFF -> 0x0000.
REQ-025 The block SHALL ignore in_data and in_mode when in_valid=0.

Reset
REQ-026 The block SHALL, when rst=1 at a rising edge, set count=0, the pointers to 0 and xfer_cnt=0, so that out_valid=0 and in_ready=1 in the following cycle.
REQ-027 The block SHALL discard entries present at a reset applied mid-operation, count no transfer on that edge, and take precedence over any simultaneous input or output transfer.
REQ-028 The block SHALL NOT reset FIFO data storage; only control and counter state are reset.

Verification
REQ-029 The bench SHALL cover this mode sweep with defaults and out_ready=1:
- Zero-extend: 10'b1101100110 -> 16'h0366.
- Sign-extend: 10'b1000000000 -> 16'hFE00.
- Sign-extend: 10'b0111111111 -> 16'h01FF.
- Ones-extend: 10'b0011111111 -> 16'hFCFF.
- Left-align: 10'b1010101010 -> 16'hAA80.
REQ-030 The bench SHALL cover backpressure: with out_ready=0, offer 0x001, 0x002, 0x003 back-to-back. Required response:
- in_ready drops after 2 accepts.
- The third operand is held.
- Raising out_ready yields 0x0001, 0x0002, 0x0003 in order, with no loss or duplication.
REQ-031 The bench SHALL cover streaming: 100 random operands with random modes and out_ready=1 -> one result per cycle after the first, all matching the reference model, and xfer_cnt=100.
REQ-032 The bench SHALL cover a mode change after acceptance: accept 0x200 in mode 00, switch in_mode to 01 while stalled -> out_data stays 16'h0200.
REQ-033 The bench SHALL cover reset mid-operation: assert rst with 2 entries queued and out_ready=1 -> next cycle out_valid=0, in_ready=1, xfer_cnt=0, and no transfer is counted.
REQ-034 The bench SHALL cover counter wrap: force 65537 transfers -> xfer_cnt=1.
